// File: rtl/regex_multi_ctrl.sv
// Multi-channel regex coprocessor controller: host command decode,
// per-channel FSM + saturating elapsed counter, round-robin memory arbiter.
// Ports: clk/rst_n; host cmd/address/data_in -> status/data_o registers;
// shared memory read (addr/valid/data) and write (addr/data/valid) ports;
// per-channel start handshake, done/accept/error, memory request/grant/rvalid,
// broadcast read data and synchronous clear.
// Optional build macro REGEX_CTRL_TIMEOUT_EN enables the per-channel
// watchdog (TIMEOUT state after TIMEOUT_CYCLES running cycles).
module regex_multi_ctrl #(
  parameter int REG_WIDTH        = 32,
  parameter int N_CH             = 4,
  parameter int MEM_R_WIDTH      = 80,
  parameter int MEM_R_ADDR_WIDTH = 9,
  parameter int MEM_W_WIDTH      = 40,
  parameter int MEM_W_ADDR_WIDTH = 10,
  parameter int TIMEOUT_CYCLES   = 2**20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REG_WIDTH-1:0]          cmd_register,
  input  logic [REG_WIDTH-1:0]          address_register,
  input  logic [REG_WIDTH-1:0]          data_in_register,
  output logic [REG_WIDTH-1:0]          status_register,
  output logic [REG_WIDTH-1:0]          data_o_register,
  output logic [MEM_R_ADDR_WIDTH-1:0]   mem_r_addr,
  output logic                          mem_r_valid,
  input  logic [MEM_R_WIDTH-1:0]        mem_r_data,
  output logic [MEM_W_ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [MEM_W_WIDTH-1:0]        mem_w_data,
  output logic                          mem_w_valid,
  output logic [N_CH-1:0]               ch_start_valid,
  input  logic [N_CH-1:0]               ch_start_ready,
  input  logic [N_CH-1:0]               ch_done,
  input  logic [N_CH-1:0]               ch_accept,
  input  logic [N_CH-1:0]               ch_error,
  input  logic [N_CH*MEM_R_ADDR_WIDTH-1:0] ch_mem_addr,
  input  logic [N_CH-1:0]               ch_mem_valid,
  output logic [N_CH-1:0]               ch_mem_ready,
  output logic [N_CH-1:0]               ch_mem_rvalid,
  output logic [MEM_R_WIDTH-1:0]        ch_mem_data,
  output logic [N_CH-1:0]               ch_clear
);

  localparam int CW    = REG_WIDTH;
  localparam int NWORD = (MEM_R_WIDTH + REG_WIDTH - 1) / REG_WIDTH;
  localparam int WSEL  = $clog2(NWORD);
  localparam int WSW   = (WSEL > 0) ? WSEL : 1;
  localparam int PADW  = (1 << WSW) * REG_WIDTH;
  localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WMAX  = (MEM_W_WIDTH > REG_WIDTH) ? MEM_W_WIDTH
                                                   : REG_WIDTH;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef REGEX_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_READ    = 4'd2;
  localparam logic [3:0] OP_START   = 4'd3;
  localparam logic [3:0] OP_RESTART = 4'd4;
  localparam logic [3:0] OP_ELAPSED = 4'd5;
  localparam logic [3:0] OP_RESET   = 4'd6;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
  localparam logic [2:0] ST_REJ  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;
  localparam logic [2:0] ST_TO   = 3'd5;

  logic [2:0]    st  [N_CH];
  logic [CW-1:0] cnt [N_CH];

  logic [3:0] op;
  logic [2:0] sel;
  logic       sel_ok;
  logic       is_write, is_read, is_start;
  logic       is_restart, is_elapsed, is_reset;
  logic       any_run, wr_ok, rd_ok;
  logic       set_rej, clr_rej, rej;

  logic [N_CH-1:0] run, sel_hit, start_req;
  logic [N_CH-1:0] restart_req, clr_req;
  logic [N_CH-1:0] to_fire, to_pulse, elig, grant;
  logic [2:0]      sel_st;
  logic [CW-1:0]   sel_cnt;

  logic [PW-1:0]  ptr, gidx;
  logic           found;
  logic           rd_pend;
  logic [WSW-1:0] rd_word, rd_word_n;
  logic [PADW-1:0] rd_pad;
  logic [WMAX-1:0] wpad;
  logic [REG_WIDTH-1:0] status_n;

  assign op         = cmd_register[3:0];
  assign sel        = cmd_register[10:8];
  assign sel_ok     = ({1'b0, sel} < 4'(N_CH));
  assign is_write   = (op == OP_WRITE);
  assign is_read    = (op == OP_READ);
  assign is_start   = (op == OP_START);
  assign is_restart = (op == OP_RESTART);
  assign is_elapsed = (op == OP_ELAPSED);
  assign is_reset   = (op == OP_RESET);

  assign any_run = |run;
  assign wr_ok   = is_write && !any_run;
  assign rd_ok   = is_read && !any_run;
  assign clr_rej = is_reset && (sel == 3'd7);

  // Host memory access is dropped while any channel owns the read port.
  assign set_rej =
    ((is_start | is_restart | is_elapsed | is_reset)
      && !sel_ok && !clr_rej)
    || ((is_write | is_read) && any_run);

  always_comb begin
    run         = '0;
    sel_hit     = '0;
    start_req   = '0;
    restart_req = '0;
    clr_req     = '0;
    to_fire     = '0;
    elig        = '0;
    sel_st      = ST_IDLE;
    sel_cnt     = '0;
    for (int i = 0; i < N_CH; i++) begin
      run[i]         = (st[i] == ST_RUN);
      sel_hit[i]     = sel_ok && (sel == 3'(i));
      start_req[i]   = is_start && sel_hit[i]
                       && (st[i] == ST_IDLE);
      restart_req[i] = is_restart && sel_hit[i];
      clr_req[i]     = is_reset && sel_hit[i];
      to_fire[i]     = TO_EN && run[i] && !ch_error[i]
                       && !ch_done[i] && !clr_req[i]
                       && (cnt[i] == TO_LAST);
      elig[i]        = ch_mem_valid[i]
                       && (run[i] || start_req[i]);
      if (sel_hit[i]) begin
        sel_st  = st[i];
        sel_cnt = cnt[i];
      end
    end
  end

  // Round-robin: first eligible channel at or after the pointer.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && elig[(int'(ptr) + k) % N_CH]) begin
        grant[(int'(ptr) + k) % N_CH] = 1'b1;
        gidx  = PW'((int'(ptr) + k) % N_CH);
        found = 1'b1;
      end
    end
  end

  assign rd_word_n = (WSEL > 0) ? address_register[WSW-1:0]
                                : '0;
  assign rd_pad    = PADW'(mem_r_data);
  assign wpad      = WMAX'(data_in_register);

  assign mem_w_valid = wr_ok & rst_n;
  assign mem_w_addr  = address_register[MEM_W_ADDR_WIDTH-1:0];
  assign mem_w_data  = wpad[MEM_W_WIDTH-1:0];

  assign mem_r_valid = (found | rd_ok) & rst_n;
  assign mem_r_addr  = found
    ? ch_mem_addr[int'(gidx)*MEM_R_ADDR_WIDTH +: MEM_R_ADDR_WIDTH]
    : address_register[WSEL +: MEM_R_ADDR_WIDTH];

  assign ch_start_valid = start_req & {N_CH{rst_n}};
  assign ch_mem_ready   = grant & {N_CH{rst_n}};
  assign ch_mem_data    = mem_r_data;
  assign ch_clear       = (clr_req & {N_CH{rst_n}}) | to_pulse;

  always_comb begin
    status_n           = '0;
    status_n[2:0]      = sel_st;
    status_n[8]        = rej;
    status_n[16 +: N_CH] = run;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        st[i]  <= ST_IDLE;
        cnt[i] <= '0;
      end
      ptr             <= '0;
      rej             <= 1'b0;
      to_pulse        <= '0;
      ch_mem_rvalid   <= '0;
      rd_pend         <= 1'b0;
      rd_word         <= '0;
      status_register <= '0;
      data_o_register <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr_req[i]) begin
          st[i]  <= ST_IDLE;
          cnt[i] <= '0;
        end else begin
          case (st[i])
            ST_IDLE: begin
              if (start_req[i] && ch_start_ready[i]) begin
                st[i]  <= ST_RUN;
                cnt[i] <= '0;
              end
            end
            ST_RUN: begin
              if (!(&cnt[i]))
                cnt[i] <= cnt[i] + CW'(1);
              if (ch_error[i])
                st[i] <= ST_ERR;
              else if (ch_done[i])
                st[i] <= ch_accept[i] ? ST_ACC : ST_REJ;
              else if (to_fire[i])
                st[i] <= ST_TO;
            end
            default: begin
              if (restart_req[i])
                st[i] <= ST_IDLE;
            end
          endcase
        end
      end

      to_pulse      <= to_fire;
      ch_mem_rvalid <= grant;
      if (found)
        ptr <= (int'(gidx) == N_CH - 1) ? '0
                                        : gidx + PW'(1);

      if (clr_rej)
        rej <= 1'b0;
      else if (set_rej)
        rej <= 1'b1;

      status_register <= status_n;
      rd_pend         <= rd_ok;
      rd_word         <= rd_word_n;

      // Memory data for a READ lands one cycle after the address.
      if (rd_pend)
        data_o_register <=
          rd_pad[int'(rd_word)*REG_WIDTH +: REG_WIDTH];
      else if (is_elapsed && sel_ok)
        data_o_register <= sel_cnt;
    end
  end

endmodule

// File: tb/tb_regex_multi_ctrl.sv
// Directed self-checking bench for regex_multi_ctrl.
// Models a 1-cycle-latency read memory and drives host commands.
module tb_regex_multi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_register, address_register, data_in_register;
  logic [31:0] status_register, data_o_register;
  logic [8:0]  mem_r_addr;
  logic        mem_r_valid;
  logic [79:0] mem_r_data;
  logic [9:0]  mem_w_addr;
  logic [39:0] mem_w_data;
  logic        mem_w_valid;
  logic [3:0]  ch_start_valid, ch_start_ready;
  logic [3:0]  ch_done, ch_accept, ch_error;
  logic [35:0] ch_mem_addr;
  logic [3:0]  ch_mem_valid, ch_mem_ready, ch_mem_rvalid;
  logic [79:0] ch_mem_data;
  logic [3:0]  ch_clear;

  int n_cmp = 0;
  int n_err = 0;

  regex_multi_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_register(cmd_register),
    .address_register(address_register),
    .data_in_register(data_in_register),
    .status_register(status_register),
    .data_o_register(data_o_register),
    .mem_r_addr(mem_r_addr), .mem_r_valid(mem_r_valid),
    .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_valid(mem_w_valid),
    .ch_start_valid(ch_start_valid),
    .ch_start_ready(ch_start_ready),
    .ch_done(ch_done), .ch_accept(ch_accept),
    .ch_error(ch_error),
    .ch_mem_addr(ch_mem_addr), .ch_mem_valid(ch_mem_valid),
    .ch_mem_ready(ch_mem_ready), .ch_mem_rvalid(ch_mem_rvalid),
    .ch_mem_data(ch_mem_data), .ch_clear(ch_clear)
  );

  always #5 clk = ~clk;

  // word0 = C0DE_0000|addr, word1 = 5A5A_0000|addr, word2 = BEEF
  always @(posedge clk)
    mem_r_data <= {16'hBEEF,
                   32'h5A5A_0000 | 32'(mem_r_addr),
                   32'hC0DE_0000 | 32'(mem_r_addr)};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op,
                         input logic [2:0] s);
    cmd_register = {21'b0, s, 4'b0, op};
  endtask

  task automatic do_reset(input bit chk);
    rst_n            = 1'b0;
    cmd_register     = '0;
    address_register = '0;
    data_in_register = '0;
    ch_start_ready   = '0;
    ch_done          = '0;
    ch_accept        = '0;
    ch_error         = '0;
    ch_mem_addr      = '0;
    ch_mem_valid     = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    if (chk) begin
      check("rst_status", 64'(status_register), 64'd0);
      check("rst_data_o", 64'(data_o_register), 64'd0);
      check("rst_start_v", 64'(ch_start_valid), 64'd0);
      check("rst_rvalid", 64'(ch_mem_rvalid), 64'd0);
      check("rst_ready", 64'(ch_mem_ready), 64'd0);
      check("rst_clear", 64'(ch_clear), 64'd0);
      check("rst_mem_v",
            64'({mem_r_valid, mem_w_valid}), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1'b1);

    // Host WRITE: 32-bit register zero-extends onto 40-bit port
    address_register = 32'd5;
    data_in_register = 32'hCDEF_0123;
    set_cmd(4'd1, 3'd0);
    #1;
    check("wr_valid", 64'(mem_w_valid), 64'd1);
    check("wr_addr", 64'(mem_w_addr), 64'd5);
    check("wr_data", 64'(mem_w_data), 64'h00_CDEF_0123);
    tick();
    set_cmd(4'd0, 3'd0);
    tick();

    // Host READ: word select in addr[1:0], memory addr in [10:2]
    address_register = 32'h08;
    set_cmd(4'd2, 3'd0);
    #1;
    check("rd_valid", 64'(mem_r_valid), 64'd1);
    check("rd_addr", 64'(mem_r_addr), 64'd2);
    tick();
    tick();
    check("rd_w0", 64'(data_o_register), 64'hC0DE_0002);
    set_cmd(4'd0, 3'd0);
    tick();
    address_register = 32'h09;
    set_cmd(4'd2, 3'd0);
    tick();
    tick();
    check("rd_w1", 64'(data_o_register), 64'h5A5A_0002);
    address_register = 32'h0A;
    tick();
    tick();
    check("rd_w2", 64'(data_o_register), 64'h0000_BEEF);
    address_register = 32'h0B;
    tick();
    tick();
    check("rd_w3", 64'(data_o_register), 64'd0);
    set_cmd(4'd0, 3'd0);
    tick();

    // START ch0, ready arrives after 3 cycles
    set_cmd(4'd3, 3'd0);
    #1;
    check("st_valid", 64'(ch_start_valid), 64'h1);
    repeat (3) tick();
    check("st_wait", 64'(status_register), 64'h0);
    ch_start_ready = 4'b0001;
    tick();
    ch_start_ready = '0;
    check("st_valid_off", 64'(ch_start_valid), 64'h0);
    set_cmd(4'd0, 3'd0);
    repeat (99) tick();
    check("run_status", 64'(status_register), 64'h0001_0001);
    ch_done   = 4'b0001;
    ch_accept = 4'b0001;
    tick();
    ch_done   = '0;
    ch_accept = '0;
    tick();
    check("acc_status", 64'(status_register), 64'h2);
    set_cmd(4'd5, 3'd0);
    tick();
    check("elapsed100", 64'(data_o_register), 64'd100);
    set_cmd(4'd4, 3'd0);
    tick();
    set_cmd(4'd0, 3'd0);
    tick();
    check("restart", 64'(status_register), 64'h0);

    // Reject sticky bit
    set_cmd(4'd3, 3'd2);
    ch_start_ready = 4'b0100;
    tick();
    ch_start_ready = '0;
    set_cmd(4'd1, 3'd0);
    #1;
    check("wr_blocked", 64'(mem_w_valid), 64'd0);
    tick();
    set_cmd(4'd0, 3'd0);
    tick();
    check("rej_wr", 64'(status_register), 64'h0004_0100);
    set_cmd(4'd6, 3'd7);
    tick();
    set_cmd(4'd0, 3'd0);
    tick();
    check("rej_clr", 64'(status_register), 64'h0004_0000);
    set_cmd(4'd3, 3'd5);
    tick();
    set_cmd(4'd0, 3'd0);
    tick();
    check("rej_sel5", 64'(status_register), 64'h0004_0100);
    set_cmd(4'd6, 3'd7);
    tick();
    set_cmd(4'd0, 3'd0);

    // Error beats done
    ch_error  = 4'b0100;
    ch_done   = 4'b0100;
    ch_accept = 4'b0100;
    tick();
    ch_error  = '0;
    ch_done   = '0;
    ch_accept = '0;
    set_cmd(4'd0, 3'd2);
    tick();
    check("err_prec", 64'(status_register), 64'h4);
    set_cmd(4'd4, 3'd2);
    tick();
    set_cmd(4'd0, 3'd2);
    tick();
    check("err_restart", 64'(status_register), 64'h0);

    // RESET mid-run on ch1
    set_cmd(4'd3, 3'd1);
    ch_start_ready = 4'b0010;
    tick();
    ch_start_ready = '0;
    set_cmd(4'd0, 3'd1);
    repeat (10) tick();
    set_cmd(4'd5, 3'd1);
    tick();
    check("elapsed10", 64'(data_o_register), 64'd10);
    set_cmd(4'd6, 3'd1);
    #1;
    check("clr_on", 64'(ch_clear), 64'h2);
    tick();
    check("clr_held", 64'(ch_clear), 64'h2);
    set_cmd(4'd5, 3'd1);
    #1;
    check("clr_off", 64'(ch_clear), 64'h0);
    tick();
    check("rst_cnt", 64'(data_o_register), 64'd0);
    check("rst_idle", 64'(status_register), 64'h0);
    set_cmd(4'd0, 3'd0);

    // Round-robin arbitration
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      set_cmd(4'd3, 3'(i));
      ch_start_ready = 4'hF;
      tick();
    end
    set_cmd(4'd0, 3'd0);
    ch_start_ready = '0;
    ch_mem_addr  = {9'd13, 9'd12, 9'd11, 9'd10};
    ch_mem_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("arb_ready", 64'(ch_mem_ready),
            64'(4'b0001 << (k % 4)));
      check("arb_addr", 64'(mem_r_addr), 64'(10 + k % 4));
      if (k == 0)
        check("arb_rv0", 64'(ch_mem_rvalid), 64'h0);
      else begin
        check("arb_rvalid", 64'(ch_mem_rvalid),
              64'(4'b0001 << ((k - 1) % 4)));
        check("arb_data", 64'(ch_mem_data[31:0]),
              64'(32'hC0DE_0000 | 32'(10 + (k - 1) % 4)));
      end
      tick();
    end
    ch_mem_valid = '0;

    // Long run / watchdog on ch3
    do_reset(1'b0);
    set_cmd(4'd3, 3'd3);
    ch_start_ready = 4'b1000;
    tick();
    ch_start_ready = '0;
    set_cmd(4'd0, 3'd3);
`ifdef REGEX_CTRL_TIMEOUT_EN
    repeat (15) tick();
    check("to_pre_clr", 64'(ch_clear), 64'h0);
    check("to_pre_st", 64'(status_register), 64'h0008_0001);
    tick();
    check("to_clr", 64'(ch_clear), 64'h8);
    tick();
    check("to_clr_end", 64'(ch_clear), 64'h0);
    check("to_state", 64'(status_register), 64'h5);
`else
    repeat (999) tick();
    check("long_run", 64'(status_register), 64'h0008_0001);
    check("long_clr", 64'(ch_clear), 64'h0);
    set_cmd(4'd5, 3'd3);
    tick();
    check("long_cnt", 64'(data_o_register), 64'd999);
`endif
    set_cmd(4'd0, 3'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
